// File: rtl/tx_frame_seq_ctrl_if.sv
// Handshake bundle between the TX sequencer and the modulator blocks
// around it (request source, preamble, SIGNAL and DATA paths).
interface tx_frame_seq_ctrl_if #(
    parameter int NSYM_W = 12
);
    logic              tx_start;
    logic [5:0]        tx_Rate;
    logic [15:0]       packetlength;
    logic              tx_abort;
    logic              preamble_start;
    logic              preamble_done;
    logic              preamble_ready;
    logic [5:0]        sig_rate;
    logic [15:0]       sig_length;
    logic              sig_valid;
    logic              data_start;
    logic [NSYM_W-1:0] n_sym;
    logic              data_sym_done;
    logic              tx_busy;
    logic              tx_done;
    logic              tx_reject;
    logic              tx_err;

    modport slave (
        input  tx_start, tx_Rate, packetlength, tx_abort,
        input  preamble_done, sig_valid, data_sym_done,
        output preamble_start, preamble_ready, sig_rate, sig_length,
        output data_start, n_sym, tx_busy, tx_done, tx_reject, tx_err
    );

    modport master (
        output tx_start, tx_Rate, packetlength, tx_abort,
        output preamble_done, sig_valid, data_sym_done,
        input  preamble_start, preamble_ready, sig_rate, sig_length,
        input  data_start, n_sym, tx_busy, tx_done, tx_reject, tx_err
    );
endinterface

// File: rtl/tx_frame_seq_ctrl.sv
// Per-packet 802.11a TX sequencer: computes N_SYM by repeated
// subtraction, then walks PREAMBLE -> SIGNAL -> DATA with a watchdog.
module tx_frame_seq_ctrl #(
    parameter int WDOG_W = 10,
    parameter int NSYM_W = 12
) (
    input logic              clk_Modulation,
    input logic              reset_n,
    tx_frame_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, CALC, PRE, SIG_WAIT, SIG_RUN, DATA, DONE
    } state_t;

    state_t            state;
    logic [5:0]        rate_q;
    logic [15:0]       len_q;
    logic [15:0]       rem_q;
    logic [7:0]        ndbps_q;
    logic [NSYM_W-1:0] n_sym_q;
    logic [NSYM_W-1:0] sym_cnt;
    logic [WDOG_W-1:0] wdog_q;
    logic              sig_valid_q;
    logic              busy_q;
    logic              pre_start_q, pre_ready_q, data_start_q;
    logic              done_q, reject_q, err_q;

    logic [7:0]  ndbps_d;
    logic        rate_ok;
    logic        len_ok;
    logic [15:0] bits_d;
    logic        wd_active;
    logic        hs;

    always_comb begin
        ndbps_d = 8'd0;
        rate_ok = 1'b1;
        case (bus.tx_Rate)
            6'd6:    ndbps_d = 8'd24;
            6'd9:    ndbps_d = 8'd36;
            6'd12:   ndbps_d = 8'd48;
            6'd18:   ndbps_d = 8'd72;
            6'd24:   ndbps_d = 8'd96;
            6'd36:   ndbps_d = 8'd144;
            6'd48:   ndbps_d = 8'd192;
            6'd54:   ndbps_d = 8'd216;
            default: rate_ok = 1'b0;
        endcase
    end

    // SERVICE(16) + 8*LENGTH + tail(6); 16 bits since 22+8*4095 > 2**15
    assign len_ok = (bus.packetlength != 16'd0) &&
                    (bus.packetlength <= 16'd4095);
    assign bits_d = 16'd22 + {bus.packetlength[12:0], 3'b000};

    assign wd_active = (state == PRE) || (state == SIG_WAIT) ||
                       (state == SIG_RUN) || (state == DATA);
    assign hs = ((state == PRE) && bus.preamble_done) ||
                (((state == SIG_WAIT) || (state == SIG_RUN)) &&
                 (bus.sig_valid != sig_valid_q)) ||
                ((state == DATA) && bus.data_sym_done);

    always_ff @(posedge clk_Modulation or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rate_q       <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            ndbps_q      <= '0;
            n_sym_q      <= '0;
            sym_cnt      <= '0;
            wdog_q       <= '0;
            sig_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            pre_start_q  <= 1'b0;
            pre_ready_q  <= 1'b0;
            data_start_q <= 1'b0;
            done_q       <= 1'b0;
            reject_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            pre_start_q  <= 1'b0;
            pre_ready_q  <= 1'b0;
            data_start_q <= 1'b0;
            done_q       <= 1'b0;
            reject_q     <= 1'b0;
            err_q        <= 1'b0;
            sig_valid_q  <= bus.sig_valid;
            wdog_q       <= (wd_active && !hs) ? wdog_q + 1'b1 : '0;

            if (state != IDLE && bus.tx_abort) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                err_q  <= 1'b0 | 1'b1;
            end else if (wd_active && !hs && (&wdog_q)) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                err_q  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.tx_start && !bus.tx_abort) begin
                            if (rate_ok && len_ok) begin
                                state   <= CALC;
                                busy_q  <= 1'b1;
                                rate_q  <= bus.tx_Rate;
                                len_q   <= bus.packetlength;
                                rem_q   <= bits_d;
                                ndbps_q <= ndbps_d;
                                n_sym_q <= '0;
                                sym_cnt <= '0;
                            end else begin
                                reject_q <= 1'b1;
                            end
                        end
                    end
                    CALC: begin
                        n_sym_q <= n_sym_q + 1'b1;
                        if (rem_q > {8'd0, ndbps_q}) begin
                            rem_q <= rem_q - {8'd0, ndbps_q};
                        end else begin
                            state       <= PRE;
                            pre_start_q <= 1'b1;
                        end
                    end
                    PRE: begin
                        if (bus.preamble_done) begin
                            state       <= SIG_WAIT;
                            pre_ready_q <= 1'b1;
                        end
                    end
                    SIG_WAIT: begin
                        if (bus.sig_valid) state <= SIG_RUN;
                    end
                    SIG_RUN: begin
                        if (sig_valid_q && !bus.sig_valid) begin
                            state        <= DATA;
                            data_start_q <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (bus.data_sym_done) begin
                            if (sym_cnt == n_sym_q - 1'b1) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                sym_cnt <= sym_cnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.preamble_start = pre_start_q;
    assign bus.preamble_ready = pre_ready_q;
    assign bus.data_start     = data_start_q;
    assign bus.sig_rate       = rate_q;
    assign bus.sig_length     = len_q;
    assign bus.n_sym          = n_sym_q;
    assign bus.tx_busy        = busy_q;
    assign bus.tx_done        = done_q;
    assign bus.tx_reject      = reject_q;
    assign bus.tx_err         = err_q;
endmodule

// File: tb/tb_tx_frame_seq_ctrl.sv
// Directed bench for tx_frame_seq_ctrl: stimulus pushes expected pulses,
// a negedge monitor pops and compares every pulse the DUT raises.
module tb_tx_frame_seq_ctrl;
    localparam int P_PS = 0;
    localparam int P_PR = 1;
    localparam int P_DS = 2;
    localparam int P_TD = 3;
    localparam int P_RJ = 4;
    localparam int P_ER = 5;

    typedef struct packed {
        logic [5:0]  p;
        logic        chk;
        logic [11:0] ns;
    } exp_t;

    logic clk_Modulation = 1'b0;
    logic reset_n;
    always #5 clk_Modulation = ~clk_Modulation;

    tx_frame_seq_ctrl_if #(.NSYM_W(12)) bus ();

    tx_frame_seq_ctrl #(.WDOG_W(10), .NSYM_W(12)) dut (
        .clk_Modulation(clk_Modulation),
        .reset_n       (reset_n),
        .bus           (bus)
    );

    logic [5:0] pulses;
    assign pulses = {bus.tx_err, bus.tx_reject, bus.tx_done,
                     bus.data_start, bus.preamble_ready, bus.preamble_start};

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input longint act,
                         input longint want);
        total++;
        if (act == want) passed++;
        else $display("FAIL %s: got %0d want %0d", name, act, want);
    endtask

    task automatic push(input int idx, input int ns, input bit chk);
        exp_t e;
        e.p      = 6'(1 << idx);
        e.chk    = chk;
        e.ns     = 12'(ns);
        q.push_back(e);
    endtask

    always @(negedge clk_Modulation) begin
        if (reset_n && pulses != 6'd0) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_pulse: got %b want none", pulses);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse", pulses, e.p);
                if (e.chk) check("n_sym", bus.n_sym, e.ns);
            end
        end
    end

    task automatic wait_sig(input int idx, input int budget, output int cyc);
        cyc = 0;
        while (!pulses[idx] && cyc < budget) begin
            @(negedge clk_Modulation);
            cyc++;
        end
        if (!pulses[idx]) begin
            total++;
            $display("FAIL wait_pulse%0d: got none after %0d want pulse",
                     idx, cyc);
        end
    endtask

    task automatic req_to_pre(input logic [5:0] r, input logic [15:0] l,
                              input int ns);
        int cyc;
        push(P_PS, ns, 1'b1);
        @(negedge clk_Modulation);
        bus.tx_start = 1'b1;
        bus.tx_Rate = r;
        bus.packetlength = l;
        @(negedge clk_Modulation);
        bus.tx_start = 1'b0;
        check("busy_calc", bus.tx_busy, 1);
        wait_sig(P_PS, 2000, cyc);
        check("calc_cycles", cyc, ns);
        check("sig_rate", bus.sig_rate, r);
        check("sig_length", bus.sig_length, l);
    endtask

    task automatic do_preamble();
        push(P_PR, 0, 1'b0);
        @(negedge clk_Modulation);
        bus.preamble_done = 1'b1;
        @(negedge clk_Modulation);
        bus.preamble_done = 1'b0;
    endtask

    task automatic do_signal();
        int cyc;
        push(P_DS, 0, 1'b0);
        @(negedge clk_Modulation);
        bus.sig_valid = 1'b1;
        repeat (24) @(negedge clk_Modulation);
        bus.sig_valid = 1'b0;
        wait_sig(P_DS, 4, cyc);
        check("data_start_lat", cyc, 1);
    endtask

    task automatic sym_pulse();
        @(negedge clk_Modulation);
        bus.data_sym_done = 1'b1;
        @(negedge clk_Modulation);
        bus.data_sym_done = 1'b0;
    endtask

    task automatic do_data(input int n);
        int cyc;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) push(P_TD, 0, 1'b0);
            sym_pulse();
            if (i != n - 1) @(negedge clk_Modulation);
        end
        wait_sig(P_TD, 4, cyc);
        check("done_lat", cyc, 0);
        check("busy_done", bus.tx_busy, 1);
    endtask

    task automatic abort_now();
        int cyc;
        push(P_ER, 0, 1'b0);
        bus.tx_abort = 1'b1;
        @(negedge clk_Modulation);
        bus.tx_abort = 1'b0;
        wait_sig(P_ER, 4, cyc);
        check("err_lat", cyc, 0);
        check("busy_abort", bus.tx_busy, 0);
    endtask

    task automatic reject(input logic [5:0] r, input logic [15:0] l);
        int cyc;
        push(P_RJ, 0, 1'b0);
        @(negedge clk_Modulation);
        bus.tx_start = 1'b1;
        bus.tx_Rate = r;
        bus.packetlength = l;
        @(negedge clk_Modulation);
        bus.tx_start = 1'b0;
        wait_sig(P_RJ, 2, cyc);
        check("reject_lat", cyc, 0);
        check("busy_reject", bus.tx_busy, 0);
        @(negedge clk_Modulation);
        check("busy_reject2", bus.tx_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        reset_n = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_Rate = 6'd0;
        bus.packetlength = 16'd0;
        bus.tx_abort = 1'b0;
        bus.preamble_done = 1'b0;
        bus.sig_valid = 1'b0;
        bus.data_sym_done = 1'b0;
        #22;
        check("rst_busy", bus.tx_busy, 0);
        check("rst_pulses", pulses, 0);
        check("rst_nsym", bus.n_sym, 0);
        check("rst_rate", bus.sig_rate, 0);
        check("rst_len", bus.sig_length, 0);
        @(negedge clk_Modulation);
        reset_n = 1'b1;

        // full packet; tx_start during DONE must be ignored
        req_to_pre(6'd6, 16'd100, 35);
        do_preamble();
        do_signal();
        do_data(35);
        bus.tx_start = 1'b1;
        @(negedge clk_Modulation);
        bus.tx_start = 1'b0;
        check("busy_after_done", bus.tx_busy, 0);
        repeat (3) @(negedge clk_Modulation);
        check("busy_idle", bus.tx_busy, 0);

        req_to_pre(6'd54, 16'd1500, 56);
        abort_now();
        req_to_pre(6'd54, 16'd4095, 152);
        abort_now();
        req_to_pre(6'd6, 16'd4095, 1366);
        abort_now();

        reject(6'd7, 16'd100);
        reject(6'd6, 16'd0);
        reject(6'd6, 16'd4096);
        check("rate_held", bus.sig_rate, 6);
        check("len_held", bus.sig_length, 4095);

        // abort beats tx_start in IDLE
        @(negedge clk_Modulation);
        bus.tx_start = 1'b1;
        bus.tx_abort = 1'b1;
        bus.tx_Rate = 6'd12;
        bus.packetlength = 16'd10;
        @(negedge clk_Modulation);
        bus.tx_start = 1'b0;
        bus.tx_abort = 1'b0;
        @(negedge clk_Modulation);
        check("busy_idle_abort", bus.tx_busy, 0);

        req_to_pre(6'd6, 16'd100, 35);
        push(P_ER, 0, 1'b0);
        wait_sig(P_ER, 1100, cyc);
        check("wdog_cycles", cyc, 1024);
        check("busy_wdog", bus.tx_busy, 0);

        req_to_pre(6'd12, 16'd10, 3);
        do_preamble();
        do_signal();
        do_data(3);

        // abort collides with the final data_sym_done
        req_to_pre(6'd24, 16'd20, 2);
        do_preamble();
        do_signal();
        sym_pulse();
        @(negedge clk_Modulation);
        push(P_ER, 0, 1'b0);
        bus.data_sym_done = 1'b1;
        bus.tx_abort = 1'b1;
        @(negedge clk_Modulation);
        bus.data_sym_done = 1'b0;
        bus.tx_abort = 1'b0;
        wait_sig(P_ER, 4, cyc);
        check("err_data_lat", cyc, 0);
        check("busy_data_abort", bus.tx_busy, 0);
        repeat (3) @(negedge clk_Modulation);

        req_to_pre(6'd9, 16'd50, 12);
        do_preamble();
        @(negedge clk_Modulation);
        bus.sig_valid = 1'b1;
        repeat (3) @(negedge clk_Modulation);
        check("busy_sigrun", bus.tx_busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.tx_busy, 0);
        check("mid_rst_nsym", bus.n_sym, 0);
        check("mid_rst_rate", bus.sig_rate, 0);
        check("mid_rst_len", bus.sig_length, 0);
        check("mid_rst_pulses", pulses, 0);
        @(negedge clk_Modulation);
        bus.sig_valid = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk_Modulation);
        check("post_rst_busy", bus.tx_busy, 0);

        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
